control_step_sequencer: RTL and testbench



---
 rtl/control_step_sequencer.sv | 166 ++++++++++++++++
 tb/tb_control_step_sequencer.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/control_step_sequencer.sv
// Hardwired control unit: Moore FSM stepping each instruction through T0..T7,
// decoding (state, opcode, con_ff) into register-select, bus, ALU, memory and PC controls.
//
// state | meaning
// T0    | fetch: PC to MAR, increment PC
// T1    | fetch: update PC, memory read into MDR (waits on mem_ready)
// T2    | fetch: MDR to IR
// T3-T7 | execute steps, content depends on opcode
// HALT  | all controls idle, run = 0, left only by reset
module control_step_sequencer (
  input  logic        clock,
  input  logic        reset,
  input  logic [31:0] ir,
  input  logic        con_ff,
  input  logic        mem_ready,
  input  logic        stop,
  output logic        gra,
  output logic        grb,
  output logic        grc,
  output logic        rin,
  output logic        rout,
  output logic        baout,
  output logic        pc_out,
  output logic        pc_in,
  output logic        inc_pc,
  output logic        mar_in,
  output logic        mdr_in,
  output logic        mdr_out,
  output logic        ir_in,
  output logic        y_in,
  output logic        z_in,
  output logic        zlow_out,
  output logic        c_out,
  output logic        con_in,
  output logic        read,
  output logic        write,
  output logic [4:0]  alu_op,
  output logic [2:0]  step,
  output logic        run,
  output logic        illegal_op
);

  typedef enum logic [3:0] {
    T0 = 4'd0, T1 = 4'd1, T2 = 4'd2, T3 = 4'd3,
    T4 = 4'd4, T5 = 4'd5, T6 = 4'd6, T7 = 4'd7,
    HALT = 4'd8
  } state_t;

  localparam logic [4:0] OP_LD   = 5'b00000;
  localparam logic [4:0] OP_LDI  = 5'b00001;
  localparam logic [4:0] OP_ST   = 5'b00010;
  localparam logic [4:0] OP_ADD  = 5'b00011;
  localparam logic [4:0] OP_AND  = 5'b00101;
  localparam logic [4:0] OP_OR   = 5'b00110;
  localparam logic [4:0] OP_ROL  = 5'b01010;
  localparam logic [4:0] OP_ADDI = 5'b01011;
  localparam logic [4:0] OP_ANDI = 5'b01100;
  localparam logic [4:0] OP_ORI  = 5'b01101;
  localparam logic [4:0] OP_BRX  = 5'b10010;
  localparam logic [4:0] OP_JR   = 5'b10100;
  localparam logic [4:0] OP_NOP  = 5'b11010;
  localparam logic [4:0] OP_HALT = 5'b11011;

  state_t     state, state_nxt, end_st;
  logic [4:0] opcode;
  logic [4:0] imm_alu;
  logic       is_r, is_imm, is_ld, is_ldi, is_st, is_brx, is_jr, is_nop, is_halt, is_ill;
  logic       ir_unused;

  // Operand fields are turned into register enables by the select/encode logic, not here.
  assign ir_unused = ^ir[26:0];
  assign opcode    = ir[31:27];

  assign is_r    = (opcode >= OP_ADD) && (opcode <= OP_ROL);
  assign is_imm  = (opcode >= OP_ADDI) && (opcode <= OP_ORI);
  assign is_ld   = (opcode == OP_LD);
  assign is_ldi  = (opcode == OP_LDI);
  assign is_st   = (opcode == OP_ST);
  assign is_brx  = (opcode == OP_BRX);
  assign is_jr   = (opcode == OP_JR);
  assign is_nop  = (opcode == OP_NOP);
  assign is_halt = (opcode == OP_HALT);
  assign is_ill  = !(is_r || is_imm || is_ld || is_ldi || is_st || is_brx ||
                     is_jr || is_nop || is_halt);

  always_comb begin
    imm_alu = OP_ADD;
    if (opcode == OP_ANDI) imm_alu = OP_AND;
    else if (opcode == OP_ORI) imm_alu = OP_OR;
  end

  always_ff @(posedge clock) begin
    if (reset) state <= T0;
    else       state <= state_nxt;
  end

  always_comb begin
    end_st    = stop ? HALT : T0;
    state_nxt = state;
    case (state)
      T0:      state_nxt = T1;
      T1:      state_nxt = mem_ready ? T2 : T1;
      T2:      state_nxt = is_halt ? HALT : T3;
      T3:      state_nxt = (is_jr || is_nop || is_ill) ? end_st : T4;
      T4:      state_nxt = T5;
      T5:      state_nxt = (is_ld || is_st || is_brx) ? T6 : end_st;
      T6: begin
        if (is_ld)      state_nxt = mem_ready ? T7 : T6;
        else if (is_st) state_nxt = T7;
        else            state_nxt = end_st;
      end
      T7:      state_nxt = (is_st && !mem_ready) ? T7 : end_st;
      HALT:    state_nxt = HALT;
      default: state_nxt = T0;
    endcase
  end

  // Outputs are gated by reset so read/write drop in the cycle reset is seen.
  always_comb begin
    gra = 1'b0; grb = 1'b0; grc = 1'b0; rin = 1'b0; rout = 1'b0; baout = 1'b0;
    pc_out = 1'b0; pc_in = 1'b0; inc_pc = 1'b0; mar_in = 1'b0; mdr_in = 1'b0;
    mdr_out = 1'b0; ir_in = 1'b0; y_in = 1'b0; z_in = 1'b0; zlow_out = 1'b0;
    c_out = 1'b0; con_in = 1'b0; read = 1'b0; write = 1'b0; alu_op = 5'd0;
    illegal_op = 1'b0;
    step = 3'd0;
    run  = 1'b0;
    if (!reset && state != HALT) begin
      step = state[2:0];
      run  = 1'b1;
      case (state)
        T0: begin pc_out = 1'b1; mar_in = 1'b1; inc_pc = 1'b1; z_in = 1'b1; end
        T1: begin zlow_out = 1'b1; pc_in = 1'b1; read = 1'b1; mdr_in = 1'b1; end
        T2: begin mdr_out = 1'b1; ir_in = 1'b1; end
        T3: begin
          if (is_r || is_imm) begin grb = 1'b1; rout = 1'b1; y_in = 1'b1; end
          else if (is_ldi || is_ld || is_st) begin grb = 1'b1; baout = 1'b1; y_in = 1'b1; end
          else if (is_brx) begin gra = 1'b1; rout = 1'b1; con_in = 1'b1; end
          else if (is_jr) begin gra = 1'b1; rout = 1'b1; pc_in = 1'b1; end
          else if (is_ill) illegal_op = 1'b1;
        end
        T4: begin
          if (is_r) begin grc = 1'b1; rout = 1'b1; z_in = 1'b1; alu_op = opcode; end
          else if (is_imm) begin c_out = 1'b1; z_in = 1'b1; alu_op = imm_alu; end
          else if (is_ldi || is_ld || is_st) begin c_out = 1'b1; z_in = 1'b1; alu_op = OP_ADD; end
          else if (is_brx) begin pc_out = 1'b1; y_in = 1'b1; end
        end
        T5: begin
          if (is_r || is_imm || is_ldi) begin zlow_out = 1'b1; gra = 1'b1; rin = 1'b1; end
          else if (is_ld || is_st) begin zlow_out = 1'b1; mar_in = 1'b1; end
          else if (is_brx) begin c_out = 1'b1; z_in = 1'b1; alu_op = OP_ADD; end
        end
        T6: begin
          if (is_ld) begin read = 1'b1; mdr_in = 1'b1; end
          else if (is_st) begin gra = 1'b1; rout = 1'b1; mdr_in = 1'b1; end
          else if (is_brx && con_ff) begin zlow_out = 1'b1; pc_in = 1'b1; end
        end
        T7: begin
          if (is_ld) begin mdr_out = 1'b1; gra = 1'b1; rin = 1'b1; end
          else if (is_st) write = 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_control_step_sequencer.sv
// Directed bench for control_step_sequencer: per-cycle expected control words
// are queued as stimulus is applied and compared at the following falling edge.
module tb_control_step_sequencer;

  logic        clock = 1'b0;
  logic        reset, con_ff, mem_ready, stop;
  logic [31:0] ir;
  logic gra, grb, grc, rin, rout, baout, pc_out, pc_in, inc_pc, mar_in, mdr_in;
  logic mdr_out, ir_in, y_in, z_in, zlow_out, c_out, con_in, read, write;
  logic [4:0] alu_op;
  logic [2:0] step;
  logic       run, illegal_op;

  localparam logic [20:0] GRA = 21'd1 << 0,  GRB = 21'd1 << 1,  GRC = 21'd1 << 2;
  localparam logic [20:0] RIN = 21'd1 << 3,  ROUT = 21'd1 << 4, BAOUT = 21'd1 << 5;
  localparam logic [20:0] PC_OUT = 21'd1 << 6, PC_IN = 21'd1 << 7, INC_PC = 21'd1 << 8;
  localparam logic [20:0] MAR_IN = 21'd1 << 9, MDR_IN = 21'd1 << 10, MDR_OUT = 21'd1 << 11;
  localparam logic [20:0] IR_IN = 21'd1 << 12, Y_IN = 21'd1 << 13, Z_IN = 21'd1 << 14;
  localparam logic [20:0] ZLOW_OUT = 21'd1 << 15, C_OUT = 21'd1 << 16, CON_IN = 21'd1 << 17;
  localparam logic [20:0] READ = 21'd1 << 18, WRITE = 21'd1 << 19, ILL = 21'd1 << 20;
  localparam logic [20:0] NONE = 21'd0;

  typedef struct {
    string       tag;
    logic [29:0] v;
  } exp_t;

  exp_t        sb[$];
  int          n_cmp = 0;
  int          n_mis = 0;
  logic [20:0] obs_ctl;
  logic [29:0] obs;

  assign obs_ctl = {illegal_op, write, read, con_in, c_out, zlow_out, z_in, y_in, ir_in,
                    mdr_out, mdr_in, mar_in, inc_pc, pc_in, pc_out, baout, rout, rin,
                    grc, grb, gra};
  assign obs = {obs_ctl, alu_op, step, run};

  control_step_sequencer dut (
    .clock(clock), .reset(reset), .ir(ir), .con_ff(con_ff), .mem_ready(mem_ready),
    .stop(stop), .gra(gra), .grb(grb), .grc(grc), .rin(rin), .rout(rout),
    .baout(baout), .pc_out(pc_out), .pc_in(pc_in), .inc_pc(inc_pc), .mar_in(mar_in),
    .mdr_in(mdr_in), .mdr_out(mdr_out), .ir_in(ir_in), .y_in(y_in), .z_in(z_in),
    .zlow_out(zlow_out), .c_out(c_out), .con_in(con_in), .read(read), .write(write),
    .alu_op(alu_op), .step(step), .run(run), .illegal_op(illegal_op)
  );

  always #5 clock = ~clock;

  function automatic logic [31:0] mk_ir(input logic [4:0] op);
    return {op, 27'h0443000};
  endfunction

  // Queue this cycle's expectation, compare at the falling edge, then move past the next rising edge.
  task automatic cyc(input string tag, input logic [20:0] c, input logic [4:0] a,
                     input logic [2:0] s, input logic r);
    exp_t e, got;
    e.tag = tag;
    e.v   = {c, a, s, r};
    sb.push_back(e);
    @(negedge clock);
    got = sb.pop_front();
    n_cmp++;
    assert (obs === got.v) else begin
      n_mis++;
      $error("FAIL %s: observed ctl=%h alu=%h step=%0d run=%b, expected ctl=%h alu=%h step=%0d run=%b",
             got.tag, obs[29:9], obs[8:4], obs[3:1], obs[0],
             got.v[29:9], got.v[8:4], got.v[3:1], got.v[0]);
    end
    @(posedge clock);
    #1;
  endtask

  task automatic fetch(input string tag);
    cyc({tag, "_t0"}, PC_OUT | MAR_IN | INC_PC | Z_IN, 5'd0, 3'd0, 1'b1);
    cyc({tag, "_t1"}, ZLOW_OUT | PC_IN | READ | MDR_IN, 5'd0, 3'd1, 1'b1);
    cyc({tag, "_t2"}, MDR_OUT | IR_IN, 5'd0, 3'd2, 1'b1);
  endtask

  task automatic ld_addr(input string tag);
    cyc({tag, "_t3"}, GRB | BAOUT | Y_IN, 5'd0, 3'd3, 1'b1);
    cyc({tag, "_t4"}, C_OUT | Z_IN, 5'b00011, 3'd4, 1'b1);
    cyc({tag, "_t5"}, ZLOW_OUT | MAR_IN, 5'd0, 3'd5, 1'b1);
  endtask

  initial begin
    reset = 1'b1; con_ff = 1'b0; mem_ready = 1'b1; stop = 1'b0; ir = mk_ir(5'b00011);
    #1;
    cyc("rst_a", NONE, 5'd0, 3'd0, 1'b0);
    cyc("rst_b", NONE, 5'd0, 3'd0, 1'b0);
    reset = 1'b0;

    fetch("add");
    cyc("add_t3", GRB | ROUT | Y_IN, 5'd0, 3'd3, 1'b1);
    cyc("add_t4", GRC | ROUT | Z_IN, 5'b00011, 3'd4, 1'b1);
    cyc("add_t5", ZLOW_OUT | GRA | RIN, 5'd0, 3'd5, 1'b1);

    ir = mk_ir(5'b00000);
    fetch("ld");
    ld_addr("ld");
    mem_ready = 1'b0;
    for (int i = 0; i < 3; i++) cyc("ld_t6_wait", READ | MDR_IN, 5'd0, 3'd6, 1'b1);
    mem_ready = 1'b1;
    cyc("ld_t6_go", READ | MDR_IN, 5'd0, 3'd6, 1'b1);
    cyc("ld_t7", MDR_OUT | GRA | RIN, 5'd0, 3'd7, 1'b1);

    ir = mk_ir(5'b00010);
    cyc("st_t0", PC_OUT | MAR_IN | INC_PC | Z_IN, 5'd0, 3'd0, 1'b1);
    mem_ready = 1'b0;
    cyc("st_t1_wait", ZLOW_OUT | PC_IN | READ | MDR_IN, 5'd0, 3'd1, 1'b1);
    mem_ready = 1'b1;
    cyc("st_t1_go", ZLOW_OUT | PC_IN | READ | MDR_IN, 5'd0, 3'd1, 1'b1);
    cyc("st_t2", MDR_OUT | IR_IN, 5'd0, 3'd2, 1'b1);
    ld_addr("st");
    mem_ready = 1'b0;
    cyc("st_t6", GRA | ROUT | MDR_IN, 5'd0, 3'd6, 1'b1);
    cyc("st_t7_wait", WRITE, 5'd0, 3'd7, 1'b1);
    cyc("st_t7_wait", WRITE, 5'd0, 3'd7, 1'b1);
    mem_ready = 1'b1;
    cyc("st_t7_go", WRITE, 5'd0, 3'd7, 1'b1);

    ir = mk_ir(5'b10010);
    fetch("brx_tk");
    con_ff = 1'b0;
    cyc("brx_tk_t3", GRA | ROUT | CON_IN, 5'd0, 3'd3, 1'b1);
    cyc("brx_tk_t4", PC_OUT | Y_IN, 5'd0, 3'd4, 1'b1);
    cyc("brx_tk_t5", C_OUT | Z_IN, 5'b00011, 3'd5, 1'b1);
    con_ff = 1'b1;
    cyc("brx_tk_t6", ZLOW_OUT | PC_IN, 5'd0, 3'd6, 1'b1);

    fetch("brx_nt");
    cyc("brx_nt_t3", GRA | ROUT | CON_IN, 5'd0, 3'd3, 1'b1);
    cyc("brx_nt_t4", PC_OUT | Y_IN, 5'd0, 3'd4, 1'b1);
    cyc("brx_nt_t5", C_OUT | Z_IN, 5'b00011, 3'd5, 1'b1);
    con_ff = 1'b0;
    cyc("brx_nt_t6", NONE, 5'd0, 3'd6, 1'b1);

    ir = mk_ir(5'b01101);
    fetch("ori");
    cyc("ori_t3", GRB | ROUT | Y_IN, 5'd0, 3'd3, 1'b1);
    cyc("ori_t4", C_OUT | Z_IN, 5'b00110, 3'd4, 1'b1);
    cyc("ori_t5", ZLOW_OUT | GRA | RIN, 5'd0, 3'd5, 1'b1);

    ir = mk_ir(5'b00001);
    fetch("ldi");
    cyc("ldi_t3", GRB | BAOUT | Y_IN, 5'd0, 3'd3, 1'b1);
    cyc("ldi_t4", C_OUT | Z_IN, 5'b00011, 3'd4, 1'b1);
    cyc("ldi_t5", ZLOW_OUT | GRA | RIN, 5'd0, 3'd5, 1'b1);

    ir = mk_ir(5'b10100);
    fetch("jr");
    cyc("jr_t3", GRA | ROUT | PC_IN, 5'd0, 3'd3, 1'b1);

    ir = mk_ir(5'b11010);
    fetch("nop");
    cyc("nop_t3", NONE, 5'd0, 3'd3, 1'b1);

    ir = mk_ir(5'b11111);
    fetch("ill");
    cyc("ill_t3", ILL, 5'd0, 3'd3, 1'b1);

    ir = mk_ir(5'b00100);
    fetch("sub_stop");
    stop = 1'b1;
    cyc("sub_t3", GRB | ROUT | Y_IN, 5'd0, 3'd3, 1'b1);
    stop = 1'b0;
    cyc("sub_t4", GRC | ROUT | Z_IN, 5'b00100, 3'd4, 1'b1);
    stop = 1'b1;
    cyc("sub_t5", ZLOW_OUT | GRA | RIN, 5'd0, 3'd5, 1'b1);
    for (int i = 0; i < 4; i++) begin
      stop = i[0];
      cyc("stop_halt", NONE, 5'd0, 3'd0, 1'b0);
    end
    reset = 1'b1;
    cyc("halt_rst", NONE, 5'd0, 3'd0, 1'b0);
    reset = 1'b0; stop = 1'b0;

    ir = mk_ir(5'b11011);
    fetch("halt");
    for (int i = 0; i < 20; i++) begin
      stop = ~i[0];
      cyc("halt_hold", NONE, 5'd0, 3'd0, 1'b0);
    end
    reset = 1'b1; stop = 1'b0;
    cyc("halt_rst2", NONE, 5'd0, 3'd0, 1'b0);
    reset = 1'b0;

    ir = mk_ir(5'b00000);
    fetch("ld_rst");
    ld_addr("ld_rst");
    mem_ready = 1'b0;
    cyc("ld_rst_t6", READ | MDR_IN, 5'd0, 3'd6, 1'b1);
    reset = 1'b1;
    cyc("ld_rst_drop", NONE, 5'd0, 3'd0, 1'b0);
    reset = 1'b0; mem_ready = 1'b1;
    cyc("ld_rst_t0", PC_OUT | MAR_IN | INC_PC | Z_IN, 5'd0, 3'd0, 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
